multicycle_control_unit: RTL



---
 rtl/multicycle_control_unit_if.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction-register fields and status flags in, datapath
// mux selects, strobes and trap/debug status out.
interface multicycle_control_unit_if #(
    parameter int ALUCTRL_W = 3
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 zero;
    logic                 mem_ready;
    logic                 pcwrite;
    logic                 irwrite;
    logic                 regwrite;
    logic                 memwrite;
    logic                 mem_req;
    logic                 adrsrc;
    logic [1:0]           alusrca;
    logic [1:0]           alusrcb;
    logic [2:0]           immsrc;
    logic [1:0]           resultsrc;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 retire;
    logic                 trap;
    logic [1:0]           trap_cause;
    logic [3:0]           state_dbg;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output pcwrite, irwrite, regwrite, memwrite, mem_req, adrsrc,
               alusrca, alusrcb, immsrc, resultsrc, alucontrol,
               retire, trap, trap_cause, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  pcwrite, irwrite, regwrite, memwrite, mem_req, adrsrc,
               alusrca, alusrcb, immsrc, resultsrc, alucontrol,
               retire, trap, trap_cause, state_dbg
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset sequencer: one instruction at a time through a shared
// memory port, with wait-state handshake, illegal-instruction and timeout traps.
module multicycle_control_unit #(
    parameter int ALUCTRL_W  = 3,
    parameter int WAIT_LIMIT = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_unit_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int              CNT_W      = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_V   = CNT_W'(WAIT_LIMIT);
    localparam bit              TIMEOUT_EN = (WAIT_LIMIT > 0);

    // Legality of a funct3/funct7 combination for the supported ALU operations.
    function automatic logic alu_legal(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic ok;
        if (f3 == 3'b011) begin
            ok = 1'b0;
        end else if (f7b5 && (f3 == 3'b101)) begin
            ok = 1'b0;
        end else if (is_r && f7b5 && (f3 != 3'b000)) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [2:0] op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? 3'd1 : 3'd0;
            3'b100:  op = 3'd4;
            3'b110:  op = 3'd3;
            3'b111:  op = 3'd2;
            3'b010:  op = 3'd5;
            3'b001:  op = 3'd6;
            3'b101:  op = 3'd7;
            default: op = 3'd0;
        endcase
        return op;
    endfunction

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        case (op)
            OP_STORE:  sel = 3'b001;
            OP_BRANCH: sel = 3'b010;
            OP_JAL:    sel = 3'b011;
            OP_LUI:    sel = 3'b100;
            default:   sel = 3'b000;
        endcase
        return sel;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [1:0]        trap_cause_r;
    logic [1:0]        cause_nxt_s;
    logic              waiting_s;
    logic              timeout_s;

    logic              pcwrite_s, irwrite_s, regwrite_s, memwrite_s, mem_req_s;
    logic              adrsrc_s, retire_s, trap_s;
    logic [1:0]        alusrca_s, alusrcb_s, resultsrc_s;
    logic [2:0]        alu_s;

    assign waiting_s = ((state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE))
                       && !bus.mem_ready;
    assign timeout_s = TIMEOUT_EN && waiting_s && (wait_cnt_r == LIMIT_V);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait-cycle counter; restarts whenever the FSM changes state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (next_state_s != state_r) begin
            wait_cnt_r <= '0;
        end else if (TIMEOUT_EN && waiting_s && (wait_cnt_r != LIMIT_V)) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Trap cause is captured on entry to TRAP and held until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_cause_r <= 2'b00;
        end else if ((state_r != S_TRAP) && (next_state_s == S_TRAP)) begin
            trap_cause_r <= cause_nxt_s;
        end else begin
            trap_cause_r <= trap_cause_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        cause_nxt_s  = 2'b00;
        case (state_r)
            S_FETCH: begin
                if (timeout_s) begin
                    next_state_s = S_TRAP;
                    cause_nxt_s  = CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                next_state_s = S_TRAP;
                cause_nxt_s  = CAUSE_ILLEGAL;
                case (bus.opcode)
                    OP_LOAD: begin
                        if ((bus.funct3 == 3'b010) || (bus.funct3 == 3'b100)) begin
                            next_state_s = S_MEMADR;
                        end else begin
                            next_state_s = S_TRAP;
                        end
                    end
                    OP_STORE: begin
                        if ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b010)) begin
                            next_state_s = S_MEMADR;
                        end else begin
                            next_state_s = S_TRAP;
                        end
                    end
                    OP_RTYPE: begin
                        if (alu_legal(bus.funct3, bus.funct7[5], 1'b1)) begin
                            next_state_s = S_EXECR;
                        end else begin
                            next_state_s = S_TRAP;
                        end
                    end
                    OP_ITYPE: begin
                        if (alu_legal(bus.funct3, bus.funct7[5], 1'b0)) begin
                            next_state_s = S_EXECI;
                        end else begin
                            next_state_s = S_TRAP;
                        end
                    end
                    OP_BRANCH: begin
                        if ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b001)) begin
                            next_state_s = S_BRANCH;
                        end else begin
                            next_state_s = S_TRAP;
                        end
                    end
                    OP_JAL:  next_state_s = S_JUMP;
                    OP_JALR: begin
                        if (bus.funct3 == 3'b000) begin
                            next_state_s = S_JALR;
                        end else begin
                            next_state_s = S_TRAP;
                        end
                    end
                    OP_LUI:  next_state_s = S_LUI;
                    default: next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR: next_state_s = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (timeout_s) begin
                    next_state_s = S_TRAP;
                    cause_nxt_s  = CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (timeout_s) begin
                    next_state_s = S_TRAP;
                    cause_nxt_s  = CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMWB:  next_state_s = S_FETCH;
            S_EXECR:  next_state_s = S_ALUWB;
            S_EXECI:  next_state_s = S_ALUWB;
            S_LUI:    next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_LINK;
            S_JALR:   next_state_s = S_LINK;
            S_LINK:   next_state_s = S_FETCH;
            S_TRAP:   next_state_s = S_TRAP;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Output decode; FETCH, BRANCH and MEMWRITE have Mealy terms on the inputs.
    always_comb begin
        pcwrite_s   = 1'b0;
        irwrite_s   = 1'b0;
        regwrite_s  = 1'b0;
        memwrite_s  = 1'b0;
        mem_req_s   = 1'b0;
        adrsrc_s    = 1'b0;
        retire_s    = 1'b0;
        trap_s      = 1'b0;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        resultsrc_s = 2'b00;
        alu_s       = 3'd0;
        case (state_r)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                irwrite_s   = bus.mem_ready;
                pcwrite_s   = bus.mem_ready;
            end
            S_DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
            end
            S_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adrsrc_s  = 1'b1;
            end
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = 1'b1;
                retire_s    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s  = 1'b1;
                adrsrc_s   = 1'b1;
                memwrite_s = 1'b1;
                retire_s   = bus.mem_ready;
            end
            S_EXECR: begin
                alusrca_s = 2'b10;
                alu_s     = alu_op(bus.funct3, bus.funct7[5], 1'b1);
            end
            S_EXECI: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                alu_s     = alu_op(bus.funct3, bus.funct7[5], 1'b0);
            end
            S_LUI: begin
                alusrca_s = 2'b11;
                alusrcb_s = 2'b01;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s = 2'b10;
                alu_s     = 3'd1;
                pcwrite_s = bus.funct3[0] ? !bus.zero : bus.zero;
                retire_s  = 1'b1;
            end
            S_JUMP: begin
                pcwrite_s = 1'b1;
            end
            S_JALR: begin
                alusrca_s   = 2'b10;
                alusrcb_s   = 2'b01;
                resultsrc_s = 2'b10;
                pcwrite_s   = 1'b1;
            end
            S_LINK: begin
                alusrca_s   = 2'b01;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                regwrite_s  = 1'b1;
                retire_s    = 1'b1;
            end
            S_TRAP: begin
                trap_s = 1'b1;
            end
            default: begin
                trap_s = 1'b0;
            end
        endcase
    end

    // Strobes are forced low while reset is held so an aborted access never fires.
    assign bus.pcwrite    = pcwrite_s  & rst_n;
    assign bus.irwrite    = irwrite_s  & rst_n;
    assign bus.regwrite   = regwrite_s & rst_n;
    assign bus.memwrite   = memwrite_s & rst_n;
    assign bus.mem_req    = mem_req_s  & rst_n;
    assign bus.retire     = retire_s   & rst_n;
    assign bus.trap       = trap_s     & rst_n;
    assign bus.adrsrc     = adrsrc_s;
    assign bus.alusrca    = alusrca_s;
    assign bus.alusrcb    = alusrcb_s;
    assign bus.resultsrc  = resultsrc_s;
    assign bus.immsrc     = imm_sel(bus.opcode);
    assign bus.alucontrol = ALUCTRL_W'(alu_s);
    assign bus.trap_cause = trap_cause_r;
    assign bus.state_dbg  = state_r;

endmodule
